// File: rtl/sample_scheduler.sv
// Periodic ADC sample scheduler: paces conversion requests, buffers results in a
// small FIFO and drains them to an EEPROM writer at sequential addresses.
module sample_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_SIZE   = 32768,
  parameter int TIMEOUT    = 16
) (
  input  logic        adcclock,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [15:0] i_interval,
  output logic        o_conv_req,
  input  logic [7:0]  i_sample,
  input  logic        i_sample_strobe,
  output logic        o_wr_req,
  output logic [7:0]  o_wr_data,
  output logic [15:0] o_wr_addr,
  input  logic        i_wr_ack,
  output logic        o_busy,
  output logic        o_full,
  output logic        o_overrun,
  output logic        o_timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] TO_LOAD  = 16'(TIMEOUT - 1);
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
  localparam logic [16:0] ADDR_END = 17'(MEM_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CONVERT} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [15:0] w_reload;
  logic        w_fire;
  logic        w_timeout;

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic        w_fifo_empty, w_fifo_full;
  logic        w_push, w_pop, w_push_ok;

  logic        r_wr_req;
  logic [7:0]  r_wr_data;
  logic [16:0] r_wr_addr;
  logic [16:0] w_addr_inc;
  logic        r_full, r_overrun, r_timeout_err;

  // An interval of zero would never reach the cnt==1 fire point, so it runs as 1.
  assign w_reload = (i_interval == 16'd0) ? 16'd1 : i_interval;
  assign w_fire   = (r_state == S_ARMED) && (r_cnt <= 16'd1) && !r_full;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start && !r_full) begin
          w_state_nxt = S_ARMED;
          w_cnt_nxt   = w_reload;
        end
      end
      S_ARMED: begin
        if (w_fire) begin
          w_state_nxt = S_CONVERT;
          w_cnt_nxt   = TO_LOAD;
        end else if (r_cnt > 16'd1) begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_CONVERT: begin
        if (i_sample_strobe) begin
          w_state_nxt = S_ARMED;
          w_cnt_nxt   = w_reload;
        end else if (r_cnt == 16'd0) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_ARMED;
          w_cnt_nxt   = w_reload;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_stop || r_full) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 16'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge adcclock or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  // A strobe arriving with stop is still a completed conversion and is kept.
  assign w_push       = (r_state == S_CONVERT) && i_sample_strobe;
  assign w_pop        = r_wr_req && i_wr_ack;
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok    = w_push && (!w_fifo_full || w_pop);

  // NOTE: the sample storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge adcclock) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_sample;
  end

  always_ff @(posedge adcclock or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_push_ok) r_overrun <= 1'b1;
    end
  end

  // Address kept one bit wider than the port so reaching MEM_SIZE is detectable without wrap.
  assign w_addr_inc = r_wr_addr + 17'd1;

  always_ff @(posedge adcclock or negedge rst) begin
    if (!rst) begin
      r_wr_req  <= 1'b0;
      r_wr_data <= 8'd0;
      r_wr_addr <= 17'd0;
      r_full    <= 1'b0;
    end else if (r_wr_req) begin
      if (i_wr_ack) begin
        r_wr_req  <= 1'b0;
        r_wr_addr <= w_addr_inc;
        if (w_addr_inc == ADDR_END) r_full <= 1'b1;
      end
    end else if (!w_fifo_empty && !r_full) begin
      r_wr_req  <= 1'b1;
      r_wr_data <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  assign o_conv_req    = w_fire;
  assign o_busy        = (r_state != S_IDLE);
  assign o_wr_req      = r_wr_req;
  assign o_wr_data     = r_wr_data;
  assign o_wr_addr     = r_wr_addr[15:0];
  assign o_full        = r_full;
  assign o_overrun     = r_overrun;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler: pacing, write handshake, overrun, timeout,
// full-memory stop and reset behaviour, using a default and a MEM_SIZE=4 instance.
module tb_sample_scheduler;

  logic        adcclock;
  logic        rst;
  logic        start, stop, strobe, wr_ack;
  logic [15:0] interval;
  logic [7:0]  sample;

  logic        conv_req, wr_req, busy, full, overrun, timeout_err;
  logic [7:0]  wr_data;
  logic [15:0] wr_addr;
  logic        s_conv_req, s_wr_req, s_busy, s_full, s_overrun, s_timeout_err;
  logic [7:0]  s_wr_data;
  logic [15:0] s_wr_addr;

  logic        sel;
  logic        m_conv_req, m_wr_req, m_busy, m_full, m_overrun, m_timeout_err;
  logic [7:0]  m_wr_data;
  logic [15:0] m_wr_addr;

  sample_scheduler dut (
    .adcclock(adcclock), .rst(rst), .i_start(start), .i_stop(stop),
    .i_interval(interval), .o_conv_req(conv_req), .i_sample(sample),
    .i_sample_strobe(strobe), .o_wr_req(wr_req), .o_wr_data(wr_data),
    .o_wr_addr(wr_addr), .i_wr_ack(wr_ack), .o_busy(busy), .o_full(full),
    .o_overrun(overrun), .o_timeout_err(timeout_err)
  );

  sample_scheduler #(.FIFO_DEPTH(4), .MEM_SIZE(4), .TIMEOUT(16)) dut_small (
    .adcclock(adcclock), .rst(rst), .i_start(start), .i_stop(stop),
    .i_interval(interval), .o_conv_req(s_conv_req), .i_sample(sample),
    .i_sample_strobe(strobe), .o_wr_req(s_wr_req), .o_wr_data(s_wr_data),
    .o_wr_addr(s_wr_addr), .i_wr_ack(wr_ack), .o_busy(s_busy), .o_full(s_full),
    .o_overrun(s_overrun), .o_timeout_err(s_timeout_err)
  );

  assign m_conv_req    = sel ? s_conv_req    : conv_req;
  assign m_wr_req      = sel ? s_wr_req      : wr_req;
  assign m_wr_data     = sel ? s_wr_data     : wr_data;
  assign m_wr_addr     = sel ? s_wr_addr     : wr_addr;
  assign m_busy        = sel ? s_busy        : busy;
  assign m_full        = sel ? s_full        : full;
  assign m_overrun     = sel ? s_overrun     : overrun;
  assign m_timeout_err = sel ? s_timeout_err : timeout_err;

  initial begin
    adcclock = 1'b0;
    forever #5 adcclock = ~adcclock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  int cyc;
  int strobe_dly, ack_dly, strobe_at, ack_at, first_to;
  logic prev_req;
  int sample_q[$];
  int conv_q[$];
  int wd_q[$];
  int wa_q[$];
  int ack_cyc_q[$];
  int rise_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_logs();
    conv_q.delete(); wd_q.delete(); wa_q.delete();
    ack_cyc_q.delete(); rise_q.delete();
    strobe_at = -1; ack_at = -1; first_to = -1;
  endtask

  // One cycle of the ADC/EEPROM responder: answers conv_req with a strobe after
  // strobe_dly cycles and wr_req with an ack after ack_dly cycles (negative = never).
  task automatic step();
    strobe = 1'b0;
    wr_ack = 1'b0;
    if (m_conv_req) begin
      conv_q.push_back(cyc);
      if (strobe_dly > 0) strobe_at = cyc + strobe_dly;
    end
    if (cyc == strobe_at && sample_q.size() > 0) begin
      strobe    = 1'b1;
      sample    = 8'(sample_q.pop_front());
      strobe_at = -1;
    end
    if (m_wr_req && !prev_req) rise_q.push_back(cyc);
    if (cyc == ack_at) begin
      wr_ack = 1'b1;
      ack_at = -1;
      if (m_wr_req) begin
        wd_q.push_back(int'(m_wr_data));
        wa_q.push_back(int'(m_wr_addr));
        ack_cyc_q.push_back(cyc);
      end
    end else if (m_wr_req && ack_at < 0 && ack_dly >= 0) begin
      ack_at = cyc + ack_dly;
    end
    if (m_timeout_err && first_to < 0) first_to = cyc;
    prev_req = m_wr_req;
    @(posedge adcclock);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_busy"},     m_busy, 0);
    check({tag, "_conv_req"}, m_conv_req, 0);
    check({tag, "_wr_req"},   m_wr_req, 0);
    check({tag, "_wr_data"},  m_wr_data, 0);
    check({tag, "_wr_addr"},  m_wr_addr, 0);
    check({tag, "_full"},     m_full, 0);
    check({tag, "_overrun"},  m_overrun, 0);
    check({tag, "_timeout"},  m_timeout_err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0; stop = 1'b0; strobe = 1'b0; wr_ack = 1'b0; sample = 8'd0;
    prev_req = 1'b0;
    clear_logs();
    repeat (2) @(posedge adcclock);
    @(negedge adcclock);
    rst = 1'b1;
    @(posedge adcclock);
    #1;
    cyc = 0;
  endtask

  initial begin
    sel = 1'b0;
    rst = 1'b0;
    start = 1'b0; stop = 1'b0; strobe = 1'b0; wr_ack = 1'b0;
    sample = 8'd0; interval = 16'd0;
    #2;
    check_reset_outs("por");

    // Pacing and write handshake: interval 5, start at cycle 10, strobe 3 after conv_req.
    do_reset();
    interval = 16'd5; strobe_dly = 3; ack_dly = 2;
    sample_q = '{32'hA1, 32'hB2};
    while (cyc < 10) step();
    check("busy_pre_start", m_busy, 0);
    start = 1'b1; step(); start = 1'b0;
    check("busy_at_11", m_busy, 1);
    while (cyc < 33) step();
    sample_q.push_back(32'hCC);
    stop = 1'b1; step(); stop = 1'b0;
    repeat (10) step();
    check("conv_cnt",  conv_q.size(), 3);
    check("conv_0",    qget(conv_q, 0), 15);
    check("conv_1",    qget(conv_q, 1), 23);
    check("conv_2",    qget(conv_q, 2), 31);
    check("wr_cnt",    wd_q.size(), 2);
    check("wr0_data",  qget(wd_q, 0), 32'hA1);
    check("wr0_addr",  qget(wa_q, 0), 0);
    check("wr1_data",  qget(wd_q, 1), 32'hB2);
    check("wr1_addr",  qget(wa_q, 1), 1);
    check("addr_2",    m_wr_addr, 2);
    check("idle_strobe_no_req", m_wr_req, 0);
    check("busy_after_stop", m_busy, 0);
    ack_at = cyc;
    step(); step();
    check("stray_ack_addr", m_wr_addr, 2);

    // Overrun: acks withheld, five samples into a four-entry buffer.
    clear_logs();
    interval = 16'd1; strobe_dly = 1; ack_dly = -1;
    sample_q = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    start = 1'b1; step(); start = 1'b0;
    repeat (12) step();
    stop = 1'b1; step(); stop = 1'b0;
    repeat (3) step();
    check("overrun_set",    m_overrun, 1);
    check("held_req",       m_wr_req, 1);
    check("held_data",      m_wr_data, 32'h11);
    check("held_no_writes", wd_q.size(), 0);
    ack_dly = 2;
    repeat (30) step();
    check("ovr_wr_cnt", wd_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovr_wr%0d_data", i), qget(wd_q, i), 32'h11 * (i + 1));
      check($sformatf("ovr_wr%0d_addr", i), qget(wa_q, i), 2 + i);
    end
    for (int i = 1; i < 4; i++)
      check($sformatf("req_gap%0d", i), qget(rise_q, i) - qget(ack_cyc_q, i - 1), 2);
    check("ovr_addr_6",  m_wr_addr, 6);
    check("ovr_req_off", m_wr_req, 0);

    // Conversion timeout: no strobe, interval 3, TIMEOUT 16.
    clear_logs();
    check("timeout_clear", m_timeout_err, 0);
    interval = 16'd3; strobe_dly = -1;
    start = 1'b1; step(); start = 1'b0;
    repeat (40) step();
    check("to_conv_gap",  qget(conv_q, 1) - qget(conv_q, 0), 19);
    check("to_flag_cyc",  first_to - qget(conv_q, 0), 17);
    check("to_flag",      m_timeout_err, 1);
    check("to_busy",      m_busy, 1);
    check("to_no_push",   m_wr_req, 0);
    stop = 1'b1; step(); stop = 1'b0;
    check("to_stopped",   m_busy, 0);

    // Start and stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    check("start_stop_idle", m_busy, 0);
    step();
    check("start_stop_idle2", m_busy, 0);

    // Reset while a write request is outstanding.
    clear_logs();
    interval = 16'd1; strobe_dly = 1; ack_dly = -1;
    sample_q = '{32'h77};
    start = 1'b1; step(); start = 1'b0;
    repeat (8) step();
    stop = 1'b1; step(); stop = 1'b0;
    check("pre_rst_req",  m_wr_req, 1);
    check("pre_rst_data", m_wr_data, 32'h77);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outs("mid_rst");
    @(negedge adcclock);
    rst = 1'b1;
    @(posedge adcclock);
    #1;
    cyc = 0;
    prev_req = 1'b0;
    clear_logs();
    sample_q = '{32'h99};
    ack_at = cyc; strobe_at = cyc;
    repeat (4) step();
    check("post_rst_req",  m_wr_req, 0);
    check("post_rst_addr", m_wr_addr, 0);
    check("post_rst_busy", m_busy, 0);

    // Memory full on the MEM_SIZE=4 instance.
    sel = 1'b1;
    do_reset();
    interval = 16'd1; strobe_dly = 1; ack_dly = 1;
    sample_q = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5, 32'hC6, 32'hC7};
    start = 1'b1; step(); start = 1'b0;
    repeat (60) step();
    check("full_set",     m_full, 1);
    check("full_busy",    m_busy, 0);
    check("full_req",     m_wr_req, 0);
    check("full_wr_cnt",  wd_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("full_wr%0d_data", i), qget(wd_q, i), 32'hC0 + i);
    check("full_last_addr", qget(wa_q, 3), 3);
    check("full_addr_4",  m_wr_addr, 4);
    start = 1'b1; step(); start = 1'b0;
    step();
    check("full_start_ignored", m_busy, 0);
    check("full_req_stays", m_wr_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_scheduler.md
SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, 4, sample buffer entries (power of two, min 2).
REQ-002 Parameter MEM_SIZE, 32768, EEPROM byte capacity; last writable address MEM_SIZE-1.
REQ-003 Parameter TIMEOUT, 16, max adcclock cycles waiting for sample_strobe after conv_req.
REQ-004 adcclock  in  1  block clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse, begin logging.
REQ-007 stop  in  1  one-cycle pulse, end logging.
REQ-008 interval  in  16  cycles between end of one conversion and next conv_req.
REQ-009 conv_req  out  1  one-cycle pulse requesting one ADC conversion.
REQ-010 sample  in  8  ADC result, valid when sample_strobe=1.
REQ-011 sample_strobe  in  1  one-cycle pulse, sample valid.
REQ-012 wr_req  out  1  EEPROM write request, held until acknowledged.
REQ-013 wr_data  out  8  byte to write; stable while wr_req=1.
REQ-014 wr_addr  out  16  target address; equals count of acknowledged writes.
REQ-015 wr_ack  in  1  one-cycle write-complete pulse from EEPROM writer.
REQ-016 busy  out  1  1 when sampler FSM not IDLE.
REQ-017 full  out  1  sticky: wr_addr reached MEM_SIZE.
REQ-018 overrun  out  1  sticky: sample dropped because FIFO full.
REQ-019 timeout_err  out  1  sticky: conversion timed out.

Function
REQ-020 Sampler FSM states IDLE, ARMED, CONVERT; busy=1 in ARMED and CONVERT.
REQ-021 IDLE: start=1 and full=0 -> ARMED, cnt loaded with max(interval,1); start ignored in ARMED/CONVERT.
REQ-022 ARMED: cnt decrements each cycle; when cnt==1, conv_req=1 that cycle, next state CONVERT.
REQ-023 Start pulse at cycle T yields first conv_req at cycle T+max(interval,1); interval=0 behaves as 1.
REQ-024 CONVERT: sample_strobe=1 -> push sample, reload cnt, -> ARMED; period = interval + conversion latency.
REQ-025 CONVERT: TIMEOUT cycles after conv_req without strobe -> timeout_err=1, reload cnt, -> ARMED, no push.
REQ-026 sample_strobe outside CONVERT ignored, no push, no flag.
REQ-027 stop=1 in any state -> IDLE next cycle; stop and start same cycle -> stop wins; strobe same cycle as stop still pushed.
REQ-028 full becoming 1 forces FSM to IDLE and blocks further start.
REQ-029 FIFO push accepted when not full, or full with pop same cycle; otherwise sample dropped, overrun=1.
REQ-030 Writer side independent of FSM: FIFO drains after stop.
REQ-031 wr_req asserts the cycle after FIFO is non-empty and no request outstanding; wr_data=FIFO head, wr_addr current.
REQ-032 wr_ack sampled only while wr_req=1; on ack: pop, wr_addr+1, wr_req=0 next cycle (min one idle cycle between requests).
REQ-033 wr_ack while wr_req=0 ignored.
REQ-034 wr_addr reaching MEM_SIZE after ack -> full=1; no further wr_req; remaining FIFO contents held, not written.
REQ-035 wr_addr never wraps; width arithmetic 17-bit internally for comparison with MEM_SIZE.
REQ-036 Sticky flags clear only by reset.

Reset
REQ-037 rst=0 asynchronously: FSM IDLE, cnt=0, FIFO empty, conv_req=0, wr_req=0, wr_data=0, wr_addr=0, busy=0, full=0, overrun=0, timeout_err=0.
REQ-038 Reset mid-write or mid-conversion abandons transaction; no ack or strobe after release has effect until new start.

Verification
REQ-039 interval=5, start at cycle 10, strobe 3 cycles after each conv_req -> conv_req at cycles 15, 23, 31; busy=1 from 11.
REQ-040 Samples 0xA1,0xB2 pushed, wr_ack 2 cycles after each wr_req -> writes 0xA1@0, 0xB2@1, wr_addr=2, one idle cycle between requests.
REQ-041 wr_ack withheld, 5 strobes with FIFO_DEPTH=4 -> 4 stored, fifth dropped, overrun=1; later acks write first 4 in order.
REQ-042 conv_req with no strobe for 16 cycles -> timeout_err=1, FSM ARMED, next conv_req interval cycles later.
REQ-043 MEM_SIZE=4, continuous sampling -> after 4th ack full=1, busy=0, wr_req stays 0, start ignored.
REQ-044 start and stop same cycle in IDLE -> stays IDLE; rst pulse during wr_req=1 -> all outputs reset values immediately.
